// File: rtl/layer3_sched_pkg.sv
// Shared constants, state encoding and width helpers for the layer-3 scheduler.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package layer3_sched_pkg;

    localparam int L3_NUM_NEURONS = 10;
    localparam int L3_NUM_INPUTS  = 16;

    // Index width: clog2 of the count, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Score width: a signed 8x8 product is 16 bits; summing n of them
    // needs clog2(n) extra bits of headroom.
    function automatic int acc_w(input int n_inputs);
        return 16 + $clog2(n_inputs);
    endfunction

    localparam int L3_ACC_W = acc_w(L3_NUM_INPUTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } l3_state_t;

endpackage

// File: rtl/layer3_dot.sv
// Signed dot product of NUM_INPUTS 8-bit activations with 8-bit weights.
// Latency: combinational (caller registers the result).
// Backpressure: none; output follows inputs.
// Ports: act_flat / weights_flat - packed signed bytes, element i at [i*8 +: 8];
//        sum - signed ACC_W-bit result, no saturation.
module layer3_dot
    import layer3_sched_pkg::*;
#(
    parameter int NUM_INPUTS = L3_NUM_INPUTS,
    parameter int ACC_W      = acc_w(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS*8-1:0]  act_flat,
    input  logic [NUM_INPUTS*8-1:0]  weights_flat,
    output logic signed [ACC_W-1:0]  sum
);

    localparam int LVLS   = $clog2(NUM_INPUTS);
    localparam int LEAVES = 1 << LVLS;

    // Level 0 holds the sign-extended products (zero-padded up to a power
    // of two); each higher level adds adjacent pairs of the level below.
    logic signed [ACC_W-1:0] tree [LVLS+1][LEAVES];

    always_comb begin
        logic signed [15:0] a16;
        logic signed [15:0] w16;
        logic signed [15:0] p16;
        a16 = '0;
        w16 = '0;
        p16 = '0;
        for (int l = 0; l <= LVLS; l++) begin
            for (int j = 0; j < LEAVES; j++) begin
                tree[l][j] = '0;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            a16 = {{8{act_flat[i*8+7]}}, act_flat[i*8 +: 8]};
            w16 = {{8{weights_flat[i*8+7]}}, weights_flat[i*8 +: 8]};
            // Range of an 8x8 signed product is -16256..16384: fits in 16 bits.
            p16 = a16 * w16;
            tree[0][i] = {{(ACC_W-16){p16[15]}}, p16};
        end
        for (int l = 0; l < LVLS; l++) begin
            for (int j = 0; j < (LEAVES >> (l + 1)); j++) begin
                tree[l+1][j] = tree[l][2*j] + tree[l][2*j+1];
            end
        end
    end

    assign sum = tree[LVLS][0];

endmodule

// File: rtl/layer3_sched.sv
// Layer-3 sequencer: latch activations, walk weight ROM, stream scores, track argmax.
// Latency: first score 3 cycles after start, 1 score/cycle, done NUM_NEURONS+3 after start.
// Backpressure: none; start is accepted only in IDLE and dropped otherwise.
// Ports: start/act_flat - run request and activations (sampled on accepted start);
//        neuron_index/weights_flat - ROM address out, ROM data in (1-cycle read);
//        score/score_idx/score_valid - per-neuron result stream;
//        busy/done/class_idx/max_score - run status and winning class.
module layer3_sched
    import layer3_sched_pkg::*;
#(
    parameter int NUM_NEURONS = L3_NUM_NEURONS,
    parameter int NUM_INPUTS  = L3_NUM_INPUTS,
    parameter int ACC_W       = acc_w(NUM_INPUTS),
    localparam int IDX_W      = idx_w(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_INPUTS*8-1:0]  act_flat,
    output logic [IDX_W-1:0]         neuron_index,
    input  logic [NUM_INPUTS*8-1:0]  weights_flat,
    output logic signed [ACC_W-1:0]  score,
    output logic [IDX_W-1:0]         score_idx,
    output logic                     score_valid,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [ACC_W-1:0]  max_score
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    l3_state_t               state;
    logic                    drain_cnt;
    logic [NUM_INPUTS*8-1:0] act_lat;
    logic                    start_acc;

    // Stage tracking the ROM read: set while the ROM is returning data for rd_idx.
    logic                    rd_vld;
    logic [IDX_W-1:0]        rd_idx;

    logic signed [ACC_W-1:0] dot_sum;
    logic                    have_max;

    assign start_acc = start && (state == ST_IDLE);

    layer3_dot #(
        .NUM_INPUTS (NUM_INPUTS),
        .ACC_W      (ACC_W)
    ) u_dot (
        .act_flat     (act_lat),
        .weights_flat (weights_flat),
        .sum          (dot_sum)
    );

    // Control FSM, ROM address counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            neuron_index <= '0;
            drain_cnt    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            act_lat      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        act_lat      <= act_flat;
                        neuron_index <= '0;
                        busy         <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Index parks on the last neuron rather than wrapping.
                    if (neuron_index == LAST_IDX) begin
                        drain_cnt <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        neuron_index <= neuron_index + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: one for the ROM stage, one for the score register.
                    if (drain_cnt) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valid/index pipeline alongside the ROM read and the score register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld      <= 1'b0;
            rd_idx      <= '0;
            score_valid <= 1'b0;
            score_idx   <= '0;
            score       <= '0;
        end else begin
            rd_vld      <= (state == ST_ISSUE);
            rd_idx      <= neuron_index;
            score_valid <= rd_vld;
            if (rd_vld) begin
                score     <= dot_sum;
                score_idx <= rd_idx;
            end
        end
    end

    // Running argmax; strict compare keeps the lower index on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_idx <= '0;
            max_score <= '0;
            have_max  <= 1'b0;
        end else if (start_acc) begin
            class_idx <= '0;
            max_score <= '0;
            have_max  <= 1'b0;
        end else if (score_valid && (!have_max || (score > max_score))) begin
            class_idx <= score_idx;
            max_score <= score;
            have_max  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer3_sched.sv
// Self-checking bench for layer3_sched with a registered weight ROM model.
// Latency: checks the 3-cycle score latency and NUM_NEURONS+3 done timing.
// Backpressure: checks that start outside IDLE is dropped.
module tb_layer3_sched;
    import layer3_sched_pkg::*;

    localparam int NN    = L3_NUM_NEURONS;
    localparam int NI    = L3_NUM_INPUTS;
    localparam int ACC_W = L3_ACC_W;
    localparam int IDX_W = idx_w(L3_NUM_NEURONS);

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [NI*8-1:0]         act_flat;
    logic [IDX_W-1:0]        neuron_index;
    logic [NI*8-1:0]         weights_flat;
    logic signed [ACC_W-1:0] score;
    logic [IDX_W-1:0]        score_idx;
    logic                    score_valid;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        class_idx;
    logic signed [ACC_W-1:0] max_score;

    int tests;
    int fails;

    logic [NI*8-1:0] rom [16];

    layer3_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .act_flat     (act_flat),
        .neuron_index (neuron_index),
        .weights_flat (weights_flat),
        .score        (score),
        .score_idx    (score_idx),
        .score_valid  (score_valid),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .max_score    (max_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight ROM: one cycle from sampled address to data.
    always @(posedge clk) weights_flat <= rom[neuron_index];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NI*8-1:0] splat(input int v);
        logic [NI*8-1:0] r;
        for (int i = 0; i < NI; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    function automatic logic [NI*8-1:0] rand_vec();
        logic [NI*8-1:0] r;
        for (int i = 0; i < NI; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic int elem(input logic [NI*8-1:0] v, input int i);
        logic signed [7:0] b;
        b = v[i*8 +: 8];
        return int'(b);
    endfunction

    task automatic check_all_zero(input string tag);
        tests++;
        if (neuron_index !== '0 || score !== '0 || score_idx !== '0 || score_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || class_idx !== '0 || max_score !== '0) begin
            fails++;
            $display("FAIL %s: outputs idx=%0d sc=%0d si=%0d sv=%0b busy=%0b done=%0b cls=%0d max=%0d, all must be 0",
                     tag, neuron_index, score, score_idx, score_valid, busy, done, class_idx, max_score);
        end
    endtask

    // One full run starting at the current negedge; returns at the negedge of cycle 14.
    task automatic do_run(input logic [NI*8-1:0] act, input bit scramble, input bit repulse,
                          input string tag);
        int exp_sc [NN];
        int best_i;
        int best_v;
        for (int n = 0; n < NN; n++) begin
            exp_sc[n] = 0;
            for (int i = 0; i < NI; i++) exp_sc[n] += elem(act, i) * elem(rom[n], i);
        end
        best_i = 0;
        best_v = exp_sc[0];
        for (int n = 1; n < NN; n++) begin
            if (exp_sc[n] > best_v) begin
                best_v = exp_sc[n];
                best_i = n;
            end
        end

        act_flat = act;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tests++;
            if (busy !== (c <= 13)) begin
                fails++;
                $display("FAIL %s c%0d busy: got %0b want %0b", tag, c, busy, (c <= 13));
            end
            if (c <= 10) begin
                tests++;
                if (neuron_index !== IDX_W'(c - 1)) begin
                    fails++;
                    $display("FAIL %s c%0d neuron_index: got %0d want %0d", tag, c, neuron_index, c - 1);
                end
            end
            tests++;
            if (score_valid !== (c >= 3 && c <= 12)) begin
                fails++;
                $display("FAIL %s c%0d score_valid: got %0b want %0b", tag, c, score_valid, (c >= 3 && c <= 12));
            end
            if (c >= 3 && c <= 12) begin
                tests++;
                if (score_idx !== IDX_W'(c - 3) || score !== ACC_W'(exp_sc[c-3])) begin
                    fails++;
                    $display("FAIL %s c%0d score: got idx %0d val %0d want idx %0d val %0d",
                             tag, c, score_idx, score, c - 3, exp_sc[c-3]);
                end
            end
            tests++;
            if (done !== (c == 13)) begin
                fails++;
                $display("FAIL %s c%0d done: got %0b want %0b", tag, c, done, (c == 13));
            end
            if (c == 1) begin
                tests++;
                if (class_idx !== '0 || max_score !== '0) begin
                    fails++;
                    $display("FAIL %s tracker clear: got cls %0d max %0d want 0 0", tag, class_idx, max_score);
                end
            end
            if (c >= 13) begin
                tests++;
                if (class_idx !== IDX_W'(best_i) || max_score !== ACC_W'(best_v)) begin
                    fails++;
                    $display("FAIL %s c%0d argmax: got cls %0d max %0d want cls %0d max %0d",
                             tag, c, class_idx, max_score, best_i, best_v);
                end
            end
            start = (repulse && (c == 5 || c == 13)) ? 1'b1 : 1'b0;
            if (scramble && c <= 11) act_flat = rand_vec();
            if (c < 14) @(negedge clk);
        end
    endtask

    task automatic idle_check(input int ncyc, input string tag);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || score_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s idle k%0d: busy=%0b done=%0b sv=%0b want 0 0 0", tag, k, busy, done, score_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        act_flat = '0;
        for (int n = 0; n < 16; n++) rom[n] = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_check(2, "post_reset");
    endtask

    task automatic test_ramp();
        for (int n = 0; n < NN; n++) rom[n] = splat(n - 5);
        do_run(splat(1), 1'b0, 1'b0, "ramp");
    endtask

    task automatic test_extreme();
        rom[0] = splat(-128);
        rom[1] = splat(127);
        for (int n = 2; n < NN; n++) rom[n] = rand_vec();
        do_run(splat(-128), 1'b0, 1'b0, "extreme");
    endtask

    task automatic test_tie();
        for (int n = 0; n < NN; n++) rom[n] = splat((n % 3) - 1);
        rom[2] = splat(3);
        rom[2][7:0] = 8'd5;
        rom[7] = splat(3);
        rom[7][NI*8-1 -: 8] = 8'd5;
        do_run(splat(1), 1'b0, 1'b0, "tie");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < NN; n++) rom[n] = rand_vec();
        do_run(rand_vec(), 1'b0, 1'b1, "repulse");
        do_run(rand_vec(), 1'b0, 1'b0, "back_to_back");
        idle_check(4, "after_b2b");
    endtask

    task automatic test_scramble();
        for (int n = 0; n < NN; n++) rom[n] = rand_vec();
        do_run(rand_vec(), 1'b1, 1'b0, "scramble");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NN; n++) rom[n] = rand_vec();
            do_run(rand_vec(), 1'b0, 1'b0, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < NN; n++) rom[n] = rand_vec();
        act_flat = rand_vec();
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("mid_reset_held");
        rst_n = 1'b1;
        idle_check(20, "mid_reset_release");
        do_run(rand_vec(), 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ramp();
        test_extreme();
        test_tie();
        test_back_to_back();
        test_scramble();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer3_sched.md
# layer3_sched

Sequencer for the layer-3 (output) stage of the inference datapath. On `start` it latches the 16 layer-2 activations. It then walks the weight ROM through all neurons, one neuron index per cycle, computes each neuron's signed dot product and streams the scores out. It also tracks the running argmax and reports the winning class with a `done` pulse, sitting between the layer-2 output register and the top-level classification result.

## Interface
- `NUM_NEURONS`, 10, neurons (classes) in layer 3; weight ROM depth.
- `NUM_INPUTS`, 16, activations per neuron; weights per ROM word.
- `ACC_W`, 20, score width: 16 + clog2(NUM_INPUTS); must hold any sum of NUM_INPUTS signed 8x8 products.
- `clk`  in  1  system clock; everything on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE, ignored otherwise.
- `act_flat`  in  NUM_INPUTS*8  signed 8-bit activations, element i at [i*8 +: 8]; sampled only on the accepted `start` edge.
- `neuron_index`  out  clog2(NUM_NEURONS)  registered address to weight ROM.
- `weights_flat`  in  NUM_INPUTS*8  ROM data, signed 8-bit, element i at [i*8 +: 8]; valid one cycle after `neuron_index` is sampled.
- `score`  out  ACC_W  signed dot product for `score_idx`.
- `score_idx`  out  clog2(NUM_NEURONS)  neuron that `score` belongs to.
- `score_valid`  out  1  `score`/`score_idx` valid this cycle.
- `busy`  out  1  high from the cycle after an accepted start through the `done` cycle.
- `done`  out  1  one-cycle pulse; `class_idx`/`max_score` valid and held until the next accepted start.
- `class_idx`  out  clog2(NUM_NEURONS)  argmax neuron.
- `max_score`  out  ACC_W  score of `class_idx`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, with `start`=1:
  - latch `act_flat`, set `neuron_index`=0, clear argmax tracker.
  - go to ISSUE.
- ISSUE: `neuron_index` increments each cycle. The cycle holding NUM_NEURONS-1 transitions to DRAIN; the index holds at NUM_NEURONS-1 and never wraps.
- DRAIN: 2 cycles, flushing the ROM stage and the score register. Then go to DONE.
- DONE: one cycle, `done`=1, then IDLE.
- Pipeline: a 2-stage valid/index shift tracks each issued index, covering ROM read and the registered score.
- Score: score = Σ sext(act[i]) * sext(w[i]).
  - Each product is 16-bit signed; the sum is computed at ACC_W bits with no saturation.
  - Registered once per neuron.
- Argmax:
  - updates on each `score_valid`.
  - Replace only if score > current max (strictly), so a tie keeps the lower index.
  - The first valid score always loads.
- Reset values:
  - all outputs 0, state IDLE, latched activations 0.
  - Asserting `rst_n` mid-operation aborts immediately. No `done` is produced and there is no partial `score_valid` after release.
- `start` during ISSUE, DRAIN or DONE is dropped, not queued.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycles 1..10: `neuron_index` = 0..9, `busy`=1.
- Cycles 3..12: `score_valid`=1 with `score_idx` = 0..9. Start-to-first-score latency is 3; throughput is 1 score/cycle.
- Cycle 13: `done`=1. `class_idx` and `max_score` already include neuron 9.
- Cycle 14: IDLE, `busy`=0; earliest cycle a new `start` is accepted.
- General: total `busy` = NUM_NEURONS+3 cycles; `done` arrives NUM_NEURONS+3 cycles after start.
- The ROM must have exactly one cycle read latency (registered address to registered data).

## Structure
- Shared package or include holds:
  - the state encodings,
  - the ACC_W derivation,
  - the index-width function (clog2 of NUM_NEURONS, minimum 1).
- Sub-module `layer3_dot`: combinational NUM_INPUTS-way signed 8x8 multiply and adder tree producing ACC_W. The score register stays in `layer3_sched`.
- FSM, index counter, valid/index pipeline and argmax live in the top module.

## Test plan
- All activations 1; ROM neuron n weights all n-5 → scores 16*(n-5) = -80..64 in cycles 3..12; `class_idx`=9, `max_score`=64, `done` at cycle 13.
- Extreme values: act all -128, neuron 0 weights all -128 → score 262144 (0x40000 at 20 bits); act all -128, weights all 127 → -260096.
- Tie: neurons 2 and 7 both score 50, rest lower → `class_idx`=2.
- `start` re-pulsed at cycles 5 and 13 → ignored, single `done`. `start` at cycle 14 → new run, with activations re-latched from the cycle-14 value.
- `act_flat` changed on cycles 1..12 → scores unchanged (latched copy used).
- `rst_n` low at cycle 6 → all outputs 0 asynchronously. After release: IDLE, no `score_valid`/`done` until a new `start`.
